// File: rtl/note_chart_scheduler.sv
// Note chart scheduler: replays a loaded chart of {lane, delay} entries as one-cycle
// dropper launch pulses and tallies hit/miss/combo statistics from the lane score pulses.
module note_chart_scheduler #(
    parameter int         NUM_LANES = 4,
    parameter int         DEPTH     = 64,
    parameter int         ADDR_W    = 6,
    parameter int         DELAY_W   = 12,
    parameter int         CNT_W     = 10,
    parameter logic [7:0] START_KEY = 8'h2c,
    parameter logic [7:0] BACK_KEY  = 8'h01,
    localparam int        LANE_W    = $clog2(NUM_LANES)
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [7:0]                keycode,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [LANE_W+DELAY_W-1:0] wr_data,
    input  logic [ADDR_W:0]           chart_len,
    input  logic [NUM_LANES-1:0]      lane_busy,
    input  logic [NUM_LANES-1:0]      lane_hit,
    input  logic [NUM_LANES-1:0]      lane_miss,
    output logic [NUM_LANES-1:0]      launch,
    output logic [1:0]                run_state,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count,
    output logic [CNT_W-1:0]          combo,
    output logic [CNT_W-1:0]          max_combo,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [1:0]       DRAIN_HOLD = 2'd2;

    logic [LANE_W+DELAY_W-1:0] chart_mem [DEPTH];

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [DELAY_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           drain_q, drain_d;
    logic [NUM_LANES-1:0] launch_q, launch_d;
    logic [CNT_W-1:0]     hit_q, hit_d;
    logic [CNT_W-1:0]     miss_q, miss_d;
    logic [CNT_W-1:0]     combo_q, combo_d;
    logic [CNT_W-1:0]     max_q, max_d;

    logic [LANE_W+DELAY_W-1:0] cur_entry;
    logic [LANE_W-1:0]         cur_lane;
    logic [DELAY_W-1:0]        cur_delay;
    logic                      last_entry;
    logic [CNT_W:0]            hit_pop, miss_pop;

    function automatic logic [CNT_W:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [CNT_W:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum = sum + {{CNT_W{1'b0}}, v[i]};
        end
        return sum;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W:0]   b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + b;
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // NOTE: chart memory has no reset; a reset must leave the loaded chart replayable.
    always_ff @(posedge frame_clk) begin
        if (wr_en && state_q == S_IDLE) begin
            chart_mem[wr_addr] <= wr_data;
        end
    end

    assign cur_entry  = chart_mem[idx_q];
    assign cur_lane   = cur_entry[LANE_W+DELAY_W-1:DELAY_W];
    assign cur_delay  = cur_entry[DELAY_W-1:0];
    assign last_entry = ({1'b0, idx_q} == chart_len - 1'b1);
    assign hit_pop    = popcount(lane_hit);
    assign miss_pop   = popcount(lane_miss);

    // NOTE: every variable gets its default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        launch_d = '0;
        hit_d    = hit_q;
        miss_d   = miss_q;
        combo_d  = combo_q;
        max_d    = max_q;

        unique case (state_q)
            S_IDLE: begin
                if (keycode == START_KEY && chart_len != '0) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                    combo_d = '0;
                    max_d   = '0;
                end
            end
            S_RUN: begin
                if (keycode == BACK_KEY) begin
                    state_d = S_IDLE;
                end else if (cnt_q < cur_delay) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!lane_busy[cur_lane]) begin
                    launch_d[cur_lane] = 1'b1;
                    cnt_d              = '0;
                    if (last_entry) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last dropper needs a couple of frames before it reports busy.
                if (keycode == BACK_KEY) begin
                    state_d = S_IDLE;
                end else if (drain_q != DRAIN_HOLD) begin
                    drain_d = drain_q + 1'b1;
                end else if (lane_busy == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (keycode == BACK_KEY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_RUN || state_q == S_DRAIN) begin
            hit_d   = sat_add(hit_q, hit_pop);
            miss_d  = sat_add(miss_q, miss_pop);
            combo_d = (lane_miss != '0) ? '0 : sat_add(combo_q, hit_pop);
            max_d   = (combo_d > max_q) ? combo_d : max_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= '0;
            launch_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            combo_q  <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            launch_q <= launch_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            combo_q  <= combo_d;
            max_q    <= max_d;
        end
    end

    assign launch     = launch_q;
    assign run_state  = state_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: doc/note_chart_scheduler.md
Name: note_chart_scheduler

Overview:
- Sequences the per-lane arrow droppers from a loadable note chart.
- Holds up to DEPTH chart entries of {lane, delay}. On start, issues one-cycle launch pulses to the addressed lane after each entry's frame delay.
- Tallies hit/miss/combo statistics from the lane score pulses.
- Sits between the keyboard keycode path and the dropper instances; all logic runs on frame_clk.

Parameters:
- NUM_LANES, 4, number of dropper lanes; lane field width is LANE_W = 2.
- DEPTH, 64, chart entries.
- ADDR_W, 6, chart address width (log2 DEPTH).
- DELAY_W, 12, per-entry frame-delay width.
- CNT_W, 10, width of the statistic counters.
- START_KEY, 8'h2c, keycode that starts a run.
- BACK_KEY, 8'h01, keycode that aborts a run or returns from DONE.

Ports:
- frame_clk  in  1  sole clock.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current key from the keyboard interface.
- wr_en  in  1  chart write strobe.
- wr_addr  in  ADDR_W  chart write address.
- wr_data  in  LANE_W+DELAY_W  entry: [13:12] lane, [11:0] delay in frames.
- chart_len  in  ADDR_W+1  number of valid entries (0..DEPTH).
- lane_busy  in  NUM_LANES  dropper is in its Normal state.
- lane_hit  in  NUM_LANES  one-cycle pulse: note in lane scored.
- lane_miss  in  NUM_LANES  one-cycle pulse: note in lane reached bottom unscored.
- launch  out  NUM_LANES  one-cycle launch pulse per lane (registered).
- run_state  out  2  0 IDLE, 1 RUN, 2 DRAIN, 3 DONE.
- hit_count  out  CNT_W  total hits.
- miss_count  out  CNT_W  total misses.
- combo  out  CNT_W  current consecutive-hit streak.
- max_combo  out  CNT_W  best streak this run.
- done  out  1  high while in DONE.

Behaviour:
- Reset clears everything asynchronously: state IDLE, idx=0, frame counter=0, launch=0, all statistics 0, done=0. Chart memory is not cleared.
- Chart writes:
  - Accepted only in IDLE, on a clock edge with wr_en=1.
  - wr_en in any other state is ignored.
  - Writes to wr_addr >= DEPTH are not possible (width-limited).
- IDLE:
  - keycode==START_KEY and chart_len!=0 -> RUN. On the same edge: idx=0, cnt=0, and all statistics cleared.
  - chart_len==0 -> stay IDLE.
- RUN, evaluated each edge with entry E=mem[idx]:
  - cnt < E.delay -> cnt++.
  - Otherwise, if lane_busy[E.lane]==0: launch[E.lane]=1 for exactly the next cycle, cnt=0, idx++.
  - Otherwise (lane busy): stall with cnt held. No launch and no skip until the lane frees.
  - Delay 0 launches on the first edge the entry is current. Minimum spacing between launches is therefore 1 cycle, i.e. back-to-back across different lanes.
  - Launch of entry chart_len-1 -> DRAIN.
- launch is never multi-hot and is 0 outside the cycle after a launch decision.
- DRAIN:
  - lane_busy is ignored for the first 2 cycles, to cover dropper latency.
  - After that, lane_busy==0 -> DONE.
- DONE: done=1; keycode==BACK_KEY -> IDLE. Statistics hold until the next start.
- Abort: keycode==BACK_KEY in RUN or DRAIN -> IDLE immediately. No further launches; statistics hold.
- START_KEY outside IDLE is ignored. BACK_KEY has priority over launch decisions on the same edge.
- Statistics are updated in RUN and DRAIN only:
  - hit_count += popcount(lane_hit), saturating at 2^CNT_W-1.
  - miss_count += popcount(lane_miss), saturating at 2^CNT_W-1.
  - Any miss bit set -> combo=0; miss dominates any same-cycle hits.
  - Otherwise combo += popcount(lane_hit), saturating.
  - max_combo = max(max_combo, next combo) on every edge.
  - Simultaneous hits on several lanes in one cycle all count.

Test Plan:
- Load {lane0,d=3},{lane2,d=0}, chart_len=2, keycode 0x2c, lanes idle -> launch=0001 exactly 4 cycles after entering RUN, launch=0100 on the following cycle; then DRAIN, then DONE once lane_busy=0.
- Entry {lane1,d=0} with lane_busy[1]=1 held 10 cycles -> no launch for 10 cycles; launch=0010 on the cycle after lane_busy[1] falls; idx advances by exactly 1.
- During RUN, apply lane_hit=1011 once, then lane_hit=0001, then lane_miss=0100 -> hit_count=4, combo 3,4,0, max_combo=4, miss_count=1.
- Same-cycle lane_hit=0001 and lane_miss=0010 from combo=5 -> combo=0, hit_count+1, miss_count+1, max_combo=5.
- Assert Reset asynchronously mid-RUN with a launch pending -> launch=0 immediately, run_state=0, counters 0. A new 0x2c reruns the retained chart from entry 0.
- Other control paths:
  - wr_en pulse in RUN -> memory unchanged (verify by rerun).
  - chart_len=0 plus 0x2c -> stays IDLE.
  - keycode 0x01 in RUN -> IDLE with no further launches.
  - 1100 hits -> hit_count saturates at 1023.
